// File: rtl/unit_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    HALTED     = 2'd2
  } hz_state_e;

  localparam int LD_CNT_W = 4;

  // Register 0 is hard-wired zero, so a load targeting it is normally harmless.
  function automatic logic load_use_hit(input logic mem_read,
                                        input logic match_rs,
                                        input logic match_rt,
                                        input logic rt_is_zero,
                                        input logic r0_hazard);
    return mem_read && (match_rs || match_rt) && (r0_hazard || !rt_is_zero);
  endfunction

endpackage

// File: rtl/unit_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface unit_hazard_ctrl_if #(
  parameter int REG_SIZE  = 5,
  parameter int CNT_WIDTH = 32
);
  logic                 i_run;
  logic                 i_branch_taken;
  logic                 i_EX_jump;
  logic                 i_MEM_jump;
  logic                 i_MEM_halt;
  logic                 i_WB_halt;
  logic                 i_ID_EX_mem_read;
  logic [REG_SIZE-1:0]  i_ID_EX_rt;
  logic [REG_SIZE-1:0]  i_IF_ID_rs;
  logic [REG_SIZE-1:0]  i_IF_ID_rt;
  logic                 i_EX_mc_busy;
  logic                 o_enable_pc;
  logic                 o_enable_IF_ID_reg;
  logic                 o_enable_ID_EX_reg;
  logic                 o_flush_IF;
  logic                 o_flush_ID;
  logic                 o_flush_EX;
  logic                 o_halted;
  logic [CNT_WIDTH-1:0] o_stall_count;

  modport master (
    output i_run, i_branch_taken, i_EX_jump, i_MEM_jump, i_MEM_halt, i_WB_halt,
           i_ID_EX_mem_read, i_ID_EX_rt, i_IF_ID_rs, i_IF_ID_rt, i_EX_mc_busy,
    input  o_enable_pc, o_enable_IF_ID_reg, o_enable_ID_EX_reg,
           o_flush_IF, o_flush_ID, o_flush_EX, o_halted, o_stall_count
  );

  modport slave (
    input  i_run, i_branch_taken, i_EX_jump, i_MEM_jump, i_MEM_halt, i_WB_halt,
           i_ID_EX_mem_read, i_ID_EX_rt, i_IF_ID_rs, i_IF_ID_rt, i_EX_mc_busy,
    output o_enable_pc, o_enable_IF_ID_reg, o_enable_ID_EX_reg,
           o_flush_IF, o_flush_ID, o_flush_EX, o_halted, o_stall_count
  );
endinterface

// File: rtl/unit_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module hazard_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 clear_n_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!clear_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/unit_hazard_ctrl.sv
// Hazard/stall controller: load-use and multi-cycle stalls, sticky halt, run gate, stall counter.
module unit_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_SIZE  = 5,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_WIDTH = 32,
  parameter int R0_HAZARD = 0
) (
  input logic              i_clk,
  input logic              i_reset_n,
  unit_hazard_ctrl_if.slave hz
);

  localparam logic [LD_CNT_W-1:0] LD_INIT = LD_CNT_W'(LOAD_LAT - 1);
  localparam logic                R0_EN   = (R0_HAZARD != 0);

  hz_state_e             state_q, state_d;
  logic [LD_CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [REG_SIZE-1:0]   ex_rt, id_rs, id_rt;
  logic                  hazard;
  logic                  stall_inc;
  logic                  en_pc, en_ifid, en_idex, fl_if, fl_id, fl_ex, halted;

  assign ex_rt = hz.i_ID_EX_rt;
  assign id_rs = hz.i_IF_ID_rs;
  assign id_rt = hz.i_IF_ID_rt;

  assign hazard = load_use_hit(hz.i_ID_EX_mem_read, ex_rt == id_rs, ex_rt == id_rt,
                               ex_rt == '0, R0_EN);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= RUN;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Priority chain, highest first; the first matching branch owns outputs and next state.
  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    en_pc     = 1'b1;
    en_ifid   = 1'b1;
    en_idex   = 1'b1;
    fl_if     = 1'b0;
    fl_id     = 1'b0;
    fl_ex     = 1'b0;
    halted    = 1'b0;
    stall_inc = 1'b0;

    if (!i_reset_n) begin
      state_d  = RUN;
      ld_cnt_d = '0;
    end else if (state_q == HALTED) begin
      en_pc   = 1'b0;
      en_ifid = 1'b0;
      en_idex = 1'b0;
      halted  = 1'b1;
    end else if (!hz.i_run) begin
      en_pc   = 1'b0;
      en_ifid = 1'b0;
      en_idex = 1'b0;
    end else if (hz.i_branch_taken) begin
      fl_if    = 1'b1;
      fl_id    = 1'b1;
      fl_ex    = 1'b1;
      state_d  = RUN;
      ld_cnt_d = '0;
    end else if (hz.i_EX_jump || hz.i_MEM_jump) begin
      fl_id    = 1'b1;
      state_d  = RUN;
      ld_cnt_d = '0;
    end else if (hz.i_MEM_halt || hz.i_WB_halt) begin
      // The flushed ID instruction no longer needs its load result, so any stall is dropped.
      fl_if    = 1'b1;
      fl_id    = 1'b1;
      fl_ex    = 1'b1;
      ld_cnt_d = '0;
      state_d  = hz.i_WB_halt ? HALTED : RUN;
    end else if (state_q == LOAD_STALL) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      fl_id     = 1'b1;
      stall_inc = 1'b1;
      if (ld_cnt_q <= LD_CNT_W'(1)) begin
        ld_cnt_d = '0;
        state_d  = RUN;
      end else begin
        ld_cnt_d = ld_cnt_q - LD_CNT_W'(1);
      end
    end else if (hazard) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      fl_id     = 1'b1;
      stall_inc = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d  = LOAD_STALL;
        ld_cnt_d = LD_INIT;
      end
    end else if (hz.i_EX_mc_busy) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      fl_ex     = 1'b1;
      stall_inc = 1'b1;
    end
  end

  hazard_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i     (i_clk),
    .clear_n_i (i_reset_n),
    .en_i      (stall_inc),
    .count_o   (hz.o_stall_count)
  );

  assign hz.o_enable_pc        = en_pc;
  assign hz.o_enable_IF_ID_reg = en_ifid;
  assign hz.o_enable_ID_EX_reg = en_idex;
  assign hz.o_flush_IF         = fl_if;
  assign hz.o_flush_ID         = fl_id;
  assign hz.o_flush_EX         = fl_ex;
  assign hz.o_halted           = halted;

endmodule

// File: tb/tb_unit_hazard_ctrl.sv
// Bench for unit_hazard_ctrl: three parameterisations share stimulus, checked against a rule-level model.
module tb_unit_hazard_ctrl;

  localparam int NI = 3;

  logic       clk;
  logic       rst_n, run, br, exj, memj, mh, wh, mrd, busy;
  logic [4:0] ex_rt, rs, rt;

  logic [6:0]  ctl [NI];
  logic [31:0] cnt [NI];

  int          n_checks = 0;
  int          n_errors = 0;

  int          rem  [NI];
  bit          hlt  [NI];
  longint      cntm [NI];
  bit          valid = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LL = (g == 0) ? 1 : 3;
    localparam int R0 = (g == 1) ? 1 : 0;
    localparam int CW = (g == 2) ? 2 : 32;

    unit_hazard_ctrl_if #(.REG_SIZE(5), .CNT_WIDTH(CW)) hz ();

    assign hz.i_run            = run;
    assign hz.i_branch_taken   = br;
    assign hz.i_EX_jump        = exj;
    assign hz.i_MEM_jump       = memj;
    assign hz.i_MEM_halt       = mh;
    assign hz.i_WB_halt        = wh;
    assign hz.i_ID_EX_mem_read = mrd;
    assign hz.i_ID_EX_rt       = ex_rt;
    assign hz.i_IF_ID_rs       = rs;
    assign hz.i_IF_ID_rt       = rt;
    assign hz.i_EX_mc_busy     = busy;

    unit_hazard_ctrl #(
      .REG_SIZE (5),
      .LOAD_LAT (LL),
      .CNT_WIDTH(CW),
      .R0_HAZARD(R0)
    ) u_dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .hz       (hz)
    );

    assign ctl[g] = {hz.o_enable_pc, hz.o_enable_IF_ID_reg, hz.o_enable_ID_EX_reg,
                     hz.o_flush_IF, hz.o_flush_ID, hz.o_flush_EX, hz.o_halted};
    assign cnt[g] = 32'(hz.o_stall_count);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit r0_of(input int k);
    return (k == 1);
  endfunction

  function automatic longint max_of(input int k);
    return (k == 2) ? 64'd3 : 64'hFFFF_FFFF;
  endfunction

  function automatic bit hazard(input int k);
    return mrd && ((ex_rt == rs) || (ex_rt == rt)) && (r0_of(k) || (ex_rt != 5'd0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output vector order: {en_pc, en_IF_ID, en_ID_EX, flush_IF, flush_ID, flush_EX, halted}.
  task automatic step();
    logic [6:0] e;
    bit         st, nh;
    int         nrem;
    #1;
    for (int k = 0; k < NI; k++) begin
      e = 7'b1110000; st = 0; nrem = rem[k]; nh = hlt[k];
      if (!rst_n) begin
        nrem = 0; nh = 0;
      end else if (hlt[k]) e = 7'b0000001;
      else if (!run) e = 7'b0000000;
      else if (br) begin
        e = 7'b1111110; nrem = 0;
      end else if (exj || memj) begin
        e = 7'b1110100; nrem = 0;
      end else if (mh || wh) begin
        e = 7'b1111110; nrem = 0; nh = nh | wh;
      end else if (rem[k] > 0) begin
        e = 7'b0010100; st = 1; nrem = rem[k] - 1;
      end else if (hazard(k)) begin
        e = 7'b0010100; st = 1; nrem = lat_of(k) - 1;
      end else if (busy) begin
        e = 7'b0000010; st = 1;
      end
      chk($sformatf("ctl[%0d]", k), 32'(ctl[k]), 32'(e));
      if (valid) chk($sformatf("cnt[%0d]", k), cnt[k], 32'(cntm[k]));
      rem[k] = nrem;
      hlt[k] = nh;
      if (!rst_n) cntm[k] = 0;
      else if (st && (cntm[k] < max_of(k))) cntm[k] = cntm[k] + 1;
    end
    if (!rst_n) valid = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; run = 1; br = 0; exj = 0; memj = 0; mh = 0; wh = 0;
    mrd = 0; busy = 0; ex_rt = 5'd7; rs = 5'd1; rt = 5'd2;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rem[k] = 0; hlt[k] = 0; cntm[k] = 0;
    end
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    step();
    chk("reset_ctl", 32'(ctl[0]), 32'h70);
    rst_n = 1;
    step();
    chk("reset_cnt", cnt[1], 32'd0);

    // Load-use hazard: one stall cycle for LOAD_LAT=1, three for LOAD_LAT=3.
    mrd = 1; ex_rt = 5'd3; rs = 5'd3;
    step();
    idle();
    step(); step(); step();
    chk("lat1_cnt", cnt[0], 32'd1);
    chk("lat3_cnt", cnt[1], 32'd3);
    chk("lat3_sat_cnt", cnt[2], 32'd3);

    // Branch in the second stall cycle aborts the multi-cycle stall.
    do_reset();
    mrd = 1; ex_rt = 5'd3; rs = 5'd3;
    step();
    idle();
    br = 1;
    #1;
    chk("abort_ctl", 32'(ctl[1]), 32'h7E);
    step();
    br = 0;
    step(); step();
    chk("abort_cnt", cnt[1], 32'd1);

    // Load into register 0.
    do_reset();
    mrd = 1; ex_rt = 5'd0; rs = 5'd0; rt = 5'd9;
    #1;
    chk("r0_off_ctl", 32'(ctl[0]), 32'h70);
    chk("r0_on_ctl", 32'(ctl[1]), 32'h14);
    step();
    idle();
    step(); step(); step();

    // Halt reaching WB makes the core sticky-halted until reset.
    do_reset();
    mh = 1; step();
    mh = 0; wh = 1; step();
    wh = 0; run = 0; step();
    run = 1;
    #1;
    chk("halted_ctl", 32'(ctl[0]), 32'h01);
    step();
    run = 0; step();
    run = 1; rst_n = 0; step();
    rst_n = 1;
    #1;
    chk("unhalt_ctl", 32'(ctl[2]), 32'h70);
    step();

    // Multi-cycle EX busy with a frozen cycle in the middle.
    do_reset();
    busy = 1; step();
    run = 0; step();
    run = 1; step(); step();
    busy = 0; step();
    chk("busy_cnt", cnt[0], 32'd3);
    do_reset();
    busy = 1;
    repeat (5) step();
    busy = 0; step();
    chk("busy5_cnt", cnt[0], 32'd5);
    chk("busy5_sat_cnt", cnt[2], 32'd3);

    // Randomised traffic biased towards register collisions.
    do_reset();
    repeat (600) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      run   = ($urandom_range(0, 9) != 0);
      br    = ($urandom_range(0, 19) == 0);
      exj   = ($urandom_range(0, 29) == 0);
      memj  = ($urandom_range(0, 29) == 0);
      mh    = ($urandom_range(0, 39) == 0);
      wh    = ($urandom_range(0, 59) == 0);
      mrd   = ($urandom_range(0, 1) == 1);
      busy  = ($urandom_range(0, 5) == 0);
      ex_rt = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unit_hazard_ctrl.md
Name: unit_hazard_ctrl

Overview:
Next-generation pipeline hazard and stall controller for the 5-stage MIPS core. It drives the same PC, IF/ID and flush controls as the current stall unit. It adds registered state:
- multi-cycle load-use stalls (parametrised memory latency)
- a multi-cycle EX unit busy stall with an ID/EX hold
- a sticky HALTED state
- a debug-unit run gate
- a saturating stall-cycle counter for the debug unit.

Parameters:
REG_SIZE, 5, register index width
LOAD_LAT, 1, stall cycles per load-use hazard (1..15)
CNT_WIDTH, 32, width of stall-cycle counter
R0_HAZARD, 0, 0: register index 0 never creates a hazard; 1: it does

Ports:
i_clk  in  1  core clock
i_reset_n  in  1  synchronous reset, active-low
i_run  in  1  debug-unit run/step enable; 0 freezes the pipeline
i_branch_taken  in  1  branch resolved taken
i_EX_jump  in  1  jump in EX
i_MEM_jump  in  1  jump in MEM
i_MEM_halt  in  1  HALT in MEM
i_WB_halt  in  1  HALT in WB
i_ID_EX_mem_read  in  1  instruction in EX is a load
i_ID_EX_rt  in  REG_SIZE  load destination
i_IF_ID_rs  in  REG_SIZE  source rs in ID
i_IF_ID_rt  in  REG_SIZE  source rt in ID
i_EX_mc_busy  in  1  multi-cycle EX unit not done
o_enable_pc  out  1  PC write enable
o_enable_IF_ID_reg  out  1  IF/ID write enable
o_enable_ID_EX_reg  out  1  ID/EX write enable
o_flush_IF  out  1  flush fetched instruction
o_flush_ID  out  1  zero DECODE control signals
o_flush_EX  out  1  zero EX control signals
o_halted  out  1  core halted
o_stall_count  out  CNT_WIDTH  total stall cycles, saturating

Behaviour:
- Registered state:
  - FSM states RUN, LOAD_STALL, HALTED.
  - Down-counter ld_cnt, 4 bits.
  - stall_cnt, CNT_WIDTH bits.
- Control outputs are combinational from state and inputs. Same-cycle response, no latency.
- Reset (i_reset_n=0 at clock edge):
  - State becomes RUN, ld_cnt=0, stall_cnt=0.
  - While reset is low, outputs are forced: enables=1, flushes=0, o_halted=0.
- Default (RUN, no event): enables=1, flushes=0.
- Output priority, highest first:
  1. HALTED: all enables=0, all flushes=0, o_halted=1. Stays HALTED until reset; ignores every input, including i_run.
  2. i_run=0: all enables=0, flushes=0. State, ld_cnt and stall_cnt hold. Not counted as a stall.
  3. i_branch_taken: flush_IF=flush_ID=flush_EX=1, enables=1. Aborts LOAD_STALL: next state RUN, ld_cnt=0.
  4. i_EX_jump or i_MEM_jump: flush_ID=1 only, enables=1. Also aborts LOAD_STALL.
  5. i_MEM_halt or i_WB_halt: all flushes=1, enables=1. If i_WB_halt=1, next state is HALTED.
  6. LOAD_STALL: enable_pc=0, enable_IF_ID=0, flush_ID=1, enable_ID_EX=1. ld_cnt decrements each cycle; on transition 1->0 the next state is RUN.
  7. Load-use hazard in RUN:
     - Condition: i_ID_EX_mem_read and (ID_EX_rt==IF_ID_rs or ID_EX_rt==IF_ID_rt).
     - If R0_HAZARD=0, ID_EX_rt==0 never matches.
     - Outputs as in item 6.
     - If LOAD_LAT>1: next state LOAD_STALL, ld_cnt=LOAD_LAT-1. If LOAD_LAT=1: remain RUN.
  8. i_EX_mc_busy: enable_pc=0, IF_ID=0, ID_EX=0, flush_EX=1. Level-sensitive, no state change.
- Stall counting: stall_cnt increments on every clock edge where enable_pc=0 due to items 6, 7 or 8. It saturates at all-ones. o_stall_count = stall_cnt.
- Simultaneous events:
  - Priority above resolves all combinations.
  - A load-use hazard coinciding with a branch/jump/halt is ignored; no stall is started.
- Reset mid-LOAD_STALL or in HALTED returns to RUN on the next edge.

Decomposition:
- Package hazard_pkg:
  - FSM state enum (RUN=2'd0, LOAD_STALL=2'd1, HALTED=2'd2)
  - LD_CNT_W=4 constant
  - load-use compare function (handles R0_HAZARD)
- Sub-module hazard_sat_counter, parametrised by CNT_WIDTH: enable, synchronous active-low clear, saturating.

Test Plan:
- LOAD_LAT=1: lw $3 in EX, ID reads rs=3 -> one cycle with enable_pc=0, flush_ID=1. Next cycle enables=1; o_stall_count=1.
- LOAD_LAT=3, same hazard -> exactly 3 stall cycles (cycle 0 combinational, plus 2 in LOAD_STALL); o_stall_count=3.
- LOAD_LAT=3, hazard then i_branch_taken in the 2nd stall cycle -> that cycle flushes all with enables=1. The FSM returns to RUN; total stall count=1.
- R0_HAZARD=0: load to $0 with rs=0 -> no stall. With R0_HAZARD=1 -> stall.
- i_MEM_halt one cycle, then i_WB_halt -> two cycles with all flushes=1. From the next cycle o_halted=1 and enables=0, persisting with i_run toggling, until i_reset_n=0 for one edge.
- i_EX_mc_busy high 4 cycles with i_run=0 in cycle 2 -> enable_ID_EX=0 throughout and flush_EX=1 in cycles 1, 3, 4. o_stall_count=3. With CNT_WIDTH=2, the count saturates at 3 on a 5-cycle busy.
